// File: rtl/dm_access_unit.sv
// dm_access_unit: CPU-side data-memory initiator.
// Takes one load/store from the MEM stage at a time, checks alignment and range,
// optionally waits WAIT_CYCLES cycles, drives one byte-enabled bus access and
// returns extended load data or an address exception code as a one-cycle pulse.
module dm_access_unit #(
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] DM_LIMIT    = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_exc,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_inst_addr
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  // Last counter value spent in WAIT; unused when WAIT_CYCLES is 0.
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t      state_reg, state_next;
  logic        run_reg;
  logic [3:0]  cnt_reg, cnt_next;
  logic [2:0]  op_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] pc_reg;
  logic [31:0] rdata_reg;
  logic [4:0]  exc_reg;

  logic        accept;
  logic        store_in;
  logic        misaligned_in;
  logic        out_of_range_in;
  logic        exc_in;
  logic        store_reg;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_ext;
  logic [3:0]  sb_lane;
  logic [3:0]  sh_lane;
  logic [3:0]  st_byteen;
  logic [31:0] st_wdata;

  assign accept          = req_valid && req_ready;
  assign store_in        = (req_op >= OP_SW);
  assign out_of_range_in = (req_addr >= DM_LIMIT);
  assign exc_in          = misaligned_in || out_of_range_in;
  assign store_reg       = (op_reg >= OP_SW);

  // Alignment rules depend on access width of the incoming request.
  always_comb begin
    misaligned_in = 1'b0;
    case (req_op)
      OP_LW, OP_SW:         misaligned_in = (req_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned_in = req_addr[0];
      default:              misaligned_in = 1'b0;
    endcase
  end

  // Per-lane enables for sub-word stores: SB hits one lane, SH one half.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign sb_lane[gi] = (addr_reg[1:0] == 2'(gi));
      assign sh_lane[gi] = (addr_reg[1] == 1'(gi / 2));
    end
  endgenerate

  // Store lane steering: enables from the address, data replicated on all lanes.
  always_comb begin
    st_byteen = 4'b0000;
    st_wdata  = 32'd0;
    case (op_reg)
      OP_SW: begin
        st_byteen = 4'b1111;
        st_wdata  = wdata_reg;
      end
      OP_SH: begin
        st_byteen = sh_lane;
        st_wdata  = {2{wdata_reg[15:0]}};
      end
      OP_SB: begin
        st_byteen = sb_lane;
        st_wdata  = {4{wdata_reg[7:0]}};
      end
      default: begin
        st_byteen = 4'b0000;
        st_wdata  = 32'd0;
      end
    endcase
  end

  // Load lane selection and sign/zero extension of the bus word.
  always_comb begin
    half_sel = addr_reg[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
    byte_sel = m_data_rdata[{addr_reg[1:0], 3'b000} +: 8];
    load_ext = 32'd0;
    case (op_reg)
      OP_LW:   load_ext = m_data_rdata;
      OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_ext = {16'd0, half_sel};
      OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_ext = {24'd0, byte_sel};
      default: load_ext = 32'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: exceptions bypass the bus entirely.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (exc_in)               state_next = S_RESP;
          else if (WAIT_CYCLES > 0) state_next = S_WAIT;
          else                      state_next = S_ACCESS;
        end
      end
      S_WAIT:   if (cnt_reg == WAIT_LAST) state_next = S_ACCESS;
      S_ACCESS: state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Wait counter advances only inside WAIT and restarts from zero otherwise.
  always_comb begin
    cnt_next = 4'd0;
    if (state_reg == S_WAIT && cnt_reg != WAIT_LAST) begin
      cnt_next = cnt_reg + 4'd1;
    end
  end

  // Request latch, exception code, load-data capture and post-reset ready gate.
  always_ff @(posedge clk) begin
    if (!reset) begin
      run_reg   <= 1'b0;
      cnt_reg   <= 4'd0;
      op_reg    <= 3'd0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      pc_reg    <= 32'd0;
      rdata_reg <= 32'd0;
      exc_reg   <= EXC_NONE;
    end else begin
      run_reg <= 1'b1;
      cnt_reg <= cnt_next;
      if (accept) begin
        op_reg    <= req_op;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        pc_reg    <= req_pc;
        rdata_reg <= 32'd0;
        if (exc_in) exc_reg <= store_in ? EXC_ADES : EXC_ADEL;
        else        exc_reg <= EXC_NONE;
      end else if (state_reg == S_ACCESS && !store_reg) begin
        rdata_reg <= load_ext;
      end
    end
  end

  // Outputs: everything forced to zero while reset is held.
  always_comb begin
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = 32'd0;
    resp_exc      = EXC_NONE;
    m_data_addr   = 32'd0;
    m_data_wdata  = 32'd0;
    m_data_byteen = 4'b0000;
    m_inst_addr   = 32'd0;
    if (reset) begin
      req_ready = (state_reg == S_IDLE) && run_reg;
      if (state_reg == S_ACCESS) begin
        m_data_addr   = addr_reg;
        m_data_wdata  = st_wdata;
        m_data_byteen = st_byteen;
        m_inst_addr   = pc_reg;
      end
      if (state_reg == S_RESP) begin
        resp_valid = 1'b1;
        resp_rdata = rdata_reg;
        resp_exc   = exc_reg;
      end
    end
  end

endmodule
